tagger_bcd_converter_falling: RTL and testbench



---
 rtl/tagger_bcd_converter_falling_pkg.sv | 16 +
 rtl/tagger_priority_encoder.sv | 38 +++
 rtl/tagger_bcd_converter_falling.sv | 53 +++++
 tb/tb_tagger_bcd_converter_falling.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tagger_bcd_converter_falling_pkg.sv
// Shared widths and helpers for the falling-edge subtime converter.
package tagger_bcd_converter_falling_pkg;

  localparam int unsigned DefaultBits = 2;

  // Number of oversampled bits per clock for a given subtime width.
  function automatic int unsigned num_samples(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

  localparam int unsigned DefaultSamples = num_samples(DefaultBits);

  typedef logic [DefaultSamples-1:0] sample_vec_t;
  typedef logic [DefaultBits-1:0]    subtime_t;

endpackage

// File: rtl/tagger_priority_encoder.sv
// Lowest-set-index encoder built as a balanced binary tree of 2:1 merges.
module tagger_priority_encoder
  import tagger_bcd_converter_falling_pkg::*;
#(
  parameter int unsigned BITS = DefaultBits
) (
  input  logic [num_samples(BITS)-1:0] vec,
  output logic [BITS-1:0]              index,
  output logic                         valid
);

  localparam int unsigned N = num_samples(BITS);

  logic [N-1:0]    tree_valid;
  logic [BITS-1:0] tree_idx [N];

  // Each level halves the node count; node j merges nodes 2j (earlier) and 2j+1 (later).
  always_comb begin
    tree_valid = vec;
    for (int i = 0; i < N; i++) begin
      tree_idx[i] = BITS'(i);
    end
    for (int l = 0; l < BITS; l++) begin
      for (int j = 0; j < (N >> (l + 1)); j++) begin
        // Index first: it must see the lower child's valid before that slot is overwritten.
        tree_idx[j]   = tree_valid[2*j] ? tree_idx[2*j] : tree_idx[2*j+1];
        tree_valid[j] = tree_valid[2*j] | tree_valid[2*j+1];
      end
    end
  end

  // Report zero when nothing is set, so the root's fall-through index never leaks out.
  always_comb begin
    valid = tree_valid[0];
    index = tree_valid[0] ? tree_idx[0] : '0;
  end

endmodule

// File: rtl/tagger_bcd_converter_falling.sv
// Converts one clock of oversampled input into the subtime of its earliest falling edge.
module tagger_bcd_converter_falling
  import tagger_bcd_converter_falling_pkg::*;
#(
  parameter int unsigned BITS = DefaultBits
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [num_samples(BITS)-1:0] samples,
  output logic [BITS-1:0]              subtimes,
  output logic                         first_sample,
  output logic                         last_sample,
  output logic                         edge_detected
);

  localparam int unsigned N = num_samples(BITS);

  logic            prev_last;
  logic [N-1:0]    falls;
  logic [BITS-1:0] enc_index;
  logic            enc_valid;

  // Falling edge at i: sample i-1 high, sample i low; index 0 looks back into the last word.
  always_comb begin
    falls = ~samples & {samples[N-2:0], prev_last};
  end

  tagger_priority_encoder #(
    .BITS (BITS)
  ) u_prio (
    .vec   (falls),
    .index (enc_index),
    .valid (enc_valid)
  );

  // Register the boundary history and all outputs together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_last     <= 1'b0;
      subtimes      <= '0;
      first_sample  <= 1'b0;
      last_sample   <= 1'b0;
      edge_detected <= 1'b0;
    end else begin
      prev_last     <= samples[N-1];
      subtimes      <= enc_index;
      first_sample  <= samples[0];
      last_sample   <= samples[N-1];
      edge_detected <= enc_valid;
    end
  end

endmodule

// File: tb/tb_tagger_bcd_converter_falling.sv
// Self-checking bench for tagger_bcd_converter_falling at BITS = 2.
module tb_tagger_bcd_converter_falling;

  logic       clk;
  logic       rst_n;
  logic [3:0] samples;
  logic [1:0] subtimes;
  logic       first_sample;
  logic       last_sample;
  logic       edge_detected;

  tagger_bcd_converter_falling #(
    .BITS (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .samples       (samples),
    .subtimes      (subtimes),
    .first_sample  (first_sample),
    .last_sample   (last_sample),
    .edge_detected (edge_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] subtimes;
    logic       first;
    logic       last;
    logic       edge_det;
  } exp_t;

  typedef struct {
    logic [3:0] prev_word;
    logic [3:0] word;
    exp_t       exp_out;
  } vec_t;

  exp_t sb[$];
  logic model_prev;
  int   n_checks;
  int   n_fail;
  int   dut_pulses;
  int   exp_pulses;

  // Reference: scan samples in time order, keep the first 1->0 transition.
  function automatic exp_t model(input logic prev, input logic [3:0] w);
    exp_t r;
    logic p;
    r = '0;
    p = prev;
    for (int i = 0; i < 4; i++) begin
      if (p && !w[i] && !r.edge_det) begin
        r.edge_det = 1'b1;
        r.subtimes = 2'(i);
      end
      p = w[i];
    end
    r.first = w[0];
    r.last  = w[3];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pop the oldest expectation and compare against the current outputs.
  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " edge_detected"}, int'(edge_detected), int'(e.edge_det));
      chk({tag, " subtimes"},      int'(subtimes),      int'(e.subtimes));
      chk({tag, " first_sample"},  int'(first_sample),  int'(e.first));
      chk({tag, " last_sample"},   int'(last_sample),   int'(e.last));
      dut_pulses += int'(edge_detected);
      exp_pulses += int'(e.edge_det);
    end
  endtask

  // Drive a word away from the clock edge, then check it 1 clock later.
  task automatic drive(input string tag, input logic [3:0] w, input exp_t e);
    samples = w;
    sb.push_back(e);
    model_prev = w[3];
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic step(input string tag, input logic [3:0] w);
    drive(tag, w, model(model_prev, w));
  endtask

  // Pulse reset between clock edges and require the outputs to clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, " rst edge_detected"}, int'(edge_detected), 0);
    chk({tag, " rst subtimes"},      int'(subtimes),      0);
    chk({tag, " rst first_sample"},  int'(first_sample),  0);
    chk({tag, " rst last_sample"},   int'(last_sample),   0);
    #1;
    rst_n = 1'b1;
    model_prev = 1'b0;
    sb.delete();
  endtask

  vec_t vecs[9];

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    dut_pulses = 0;
    exp_pulses = 0;
    model_prev = 1'b0;
    rst_n      = 1'b0;
    samples    = 4'b0000;

    // {prev_word, word, {subtimes, first, last, edge}}
    vecs[0] = '{4'b0000, 4'b0011, '{2'd2, 1'b1, 1'b0, 1'b1}};
    vecs[1] = '{4'b1111, 4'b1100, '{2'd0, 1'b0, 1'b1, 1'b1}};
    vecs[2] = '{4'b0000, 4'b0101, '{2'd1, 1'b1, 1'b0, 1'b1}};
    vecs[3] = '{4'b0000, 4'b1110, '{2'd0, 1'b0, 1'b1, 1'b0}};
    vecs[4] = '{4'b1111, 4'b0000, '{2'd0, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{4'b1111, 4'b1111, '{2'd0, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{4'b0000, 4'b0000, '{2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{4'b1000, 4'b0111, '{2'd3, 1'b1, 1'b0, 1'b1}};
    vecs[8] = '{4'b1000, 4'b1001, '{2'd1, 1'b1, 1'b1, 1'b1}};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset edge_detected", int'(edge_detected), 0);
    chk("reset subtimes",      int'(subtimes),      0);
    chk("reset first_sample",  int'(first_sample),  0);
    chk("reset last_sample",   int'(last_sample),   0);
    rst_n = 1'b1;

    // First post-reset word with a leading 0 must not see a boundary edge.
    drive("post_reset 0000", 4'b0000, '{2'd0, 1'b0, 1'b0, 1'b0});
    drive("post_reset 0110", 4'b0110, '{2'd3, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < 9; i++) begin
      step($sformatf("vec%0d prev", i), vecs[i].prev_word);
      drive($sformatf("vec%0d word", i), vecs[i].word, vecs[i].exp_out);
    end

    // Mid-stream reset discards boundary history: 1100 leaves prev_last = 1.
    step("mid 1111", 4'b1111);
    step("mid 1100", 4'b1100);
    async_reset("mid");
    drive("mid after 0000", 4'b0000, '{2'd0, 1'b0, 1'b0, 1'b0});

    // Counting sweep, each value held three clocks, with a reset in the middle.
    dut_pulses = 0;
    exp_pulses = 0;
    for (int v = 0; v < 16; v++) begin
      for (int h = 0; h < 3; h++) begin
        step($sformatf("sweep %0d.%0d", v, h), 4'(v));
        if (v == 9 && h == 0) async_reset("sweep");
      end
    end
    chk("sweep edge pulse count", dut_pulses, exp_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
